// File: rtl/seg_scan_dimmer.sv
// seg_scan_dimmer: scans NUM_DIGITS common-anode digits over one shared
// active-low segment bus. Each digit slot opens with a blanking guard and
// is followed by a PWM on-window sized by that digit's 4-bit brightness.
// An optional breathing fade caps every digit at a global level that
// ramps down to 0 and back up to 15, one step every FADE_FRAMES frames.
module seg_scan_dimmer #(
  parameter int NUM_DIGITS   = 8,
  parameter int STEP_CYCLES  = 1000,
  parameter int GUARD_CYCLES = 100,
  parameter int FADE_FRAMES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [3:0]              cfg_level,
  input  logic                    fade_en,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_tick
);

  localparam int SLOT_LEN = GUARD_CYCLES + 15 * STEP_CYCLES;
  localparam int CNT_W    = $clog2(SLOT_LEN);
  localparam int IDX_W    = $clog2(NUM_DIGITS);
  localparam int DIV_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_FRAMES - 1);

  typedef enum logic [1:0] {
    FADE_OFF,
    FADE_DOWN,
    FADE_UP
  } fade_state_t;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            bright [NUM_DIGITS];
  logic [3:0]            lvl_q;
  fade_state_t           fade_state;
  logic [3:0]            fade_lvl;
  logic [DIV_W-1:0]      fade_div;

  logic [3:0]            lvl_src;
  logic [3:0]            lvl_now;
  logic [31:0]           cnt_ext;
  logic [31:0]           on_end;
  logic                  in_guard;
  logic                  in_on;
  logic                  slot_end;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] an_sel;

  // Phase decode; at cnt==0 the level being latched is used directly so the
  // decode stays correct even with a zero-length guard.
  always_comb begin
    lvl_src = bright[idx];
    if ((fade_state != FADE_OFF) && (fade_lvl < bright[idx])) begin
      lvl_src = fade_lvl;
    end
    lvl_now   = (cnt == '0) ? lvl_src : lvl_q;
    cnt_ext   = 32'(cnt);
    on_end    = 32'(GUARD_CYCLES) + 32'(lvl_now) * 32'(STEP_CYCLES);
    in_guard  = cnt_ext < 32'(GUARD_CYCLES);
    in_on     = !in_guard && (cnt_ext < on_end);
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == IDX_LAST);
    an_sel    = '1;
    an_sel[idx] = 1'b0;
  end

  // Slot position counter, digit index and per-slot level latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      lvl_q <= 4'd15;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (cnt == '0) begin
        lvl_q <= lvl_src;
      end
    end
  end

  // Brightness register file; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        bright[i] <= 4'd15;
      end
    end else if (cfg_we && (32'(cfg_addr) < NUM_DIGITS)) begin
      bright[cfg_addr[IDX_W-1:0]] <= cfg_level;
    end
  end

  // Registered pin drivers: one anode low only inside the on-window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= 8'hFF;
      an_out     <= '1;
      frame_tick <= 1'b0;
    end else begin
      an_out     <= in_on ? an_sel : '1;
      seg_out    <= in_on ? seg_in[{idx, 3'b000} +: 8] : 8'hFF;
      frame_tick <= frame_end;
    end
  end

  // Breathing fade: steps at frame ends, drops to OFF as soon as disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fade_state <= FADE_OFF;
      fade_lvl   <= 4'd15;
      fade_div   <= '0;
    end else if (!fade_en) begin
      fade_state <= FADE_OFF;
      fade_lvl   <= 4'd15;
      fade_div   <= '0;
    end else if (frame_end) begin
      case (fade_state)
        FADE_OFF: begin
          fade_state <= FADE_DOWN;
          fade_lvl   <= 4'd15;
          fade_div   <= '0;
        end
        FADE_DOWN: begin
          if (fade_div == DIV_LAST) begin
            fade_div <= '0;
            fade_lvl <= fade_lvl - 4'd1;
            if (fade_lvl == 4'd1) begin
              fade_state <= FADE_UP;
            end
          end else begin
            fade_div <= fade_div + 1'b1;
          end
        end
        FADE_UP: begin
          if (fade_div == DIV_LAST) begin
            fade_div <= '0;
            fade_lvl <= fade_lvl + 4'd1;
            if (fade_lvl == 4'd14) begin
              fade_state <= FADE_DOWN;
            end
          end else begin
            fade_div <= fade_div + 1'b1;
          end
        end
        default: begin
          fade_state <= FADE_OFF;
          fade_lvl   <= 4'd15;
          fade_div   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_dimmer.sv
// tb_seg_scan_dimmer: directed bench for seg_scan_dimmer with a small
// configuration (4 digits, 62-cycle slots, 248-cycle frames).
module tb_seg_scan_dimmer;

  localparam int ND    = 4;
  localparam int FRAME = 248;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] seg_in;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [3:0]  cfg_level;
  logic        fade_en;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int low_cnt [ND];
  int ticks;
  int viol;

  seg_scan_dimmer #(
    .NUM_DIGITS  (4),
    .STEP_CYCLES (4),
    .GUARD_CYCLES(2),
    .FADE_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_level (cfg_level),
    .fade_en   (fade_en),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .frame_tick(frame_tick)
  );

  // Free-running clock and a cycle counter used to time-stamp events.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] addr, input logic [3:0] lvl);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_level = lvl;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic measureSlot(input int d, output int start, output int len,
                             output logic [7:0] seg, output logic [3:0] an);
    bit found = 0;
    start = -1;
    len   = 0;
    seg   = 8'h00;
    an    = 4'h0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (!an_out[d]) begin
        found = 1;
        start = cyc;
        seg   = seg_out;
        an    = an_out;
      end else begin
        @(negedge clk);
      end
    end
    if (found) begin
      while (!an_out[d] && len < 1000) begin
        len++;
        @(negedge clk);
      end
    end
  endtask

  task automatic waitTick(output int at);
    bit found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (frame_tick) found = 1;
    end
    at = cyc;
    checkOutput("tick_seen", 32'(found), 32'd1);
  endtask

  task automatic frameScan();
    for (int d = 0; d < ND; d++) low_cnt[d] = 0;
    ticks = 0;
    viol  = 0;
    repeat (FRAME) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (frame_tick) ticks++;
      if ($countones(~an_out) > 1) viol++;
      if (an_out == 4'hF && seg_out !== 8'hFF) viol++;
      for (int d = 0; d < ND; d++) begin
        if (!an_out[d]) low_cnt[d]++;
        if (an_out == ~(4'b0001 << d) && seg_out !== seg_in[8*d +: 8]) viol++;
      end
    end
  endtask

  task automatic checkFrame(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp [ND];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int d = 0; d < ND; d++) begin
      checkOutput($sformatf("%s_on_d%0d", tag, d), 32'(low_cnt[d]), 32'(exp[d]));
    end
    checkOutput({tag, "_ticks"}, 32'(ticks), 32'd1);
    checkOutput({tag, "_invariants"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int rel0, st, ln, at, k, lvl;
    int st2, ln2, st3, ln3;
    logic [7:0] sg;
    logic [3:0] an;
    bit found;

    rst_n     = 1'b0;
    seg_in    = 32'h003F065B;
    cfg_we    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_level = 4'd0;
    fade_en   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_seg", 32'(seg_out), 32'hFF);
    checkOutput("reset_an", 32'(an_out), 32'hF);
    checkOutput("reset_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
    rel0  = cyc;

    // Default scan: digit 0 then digit 1
    measureSlot(0, st, ln, sg, an);
    checkOutput("d0_start", 32'(st - rel0), 32'd3);
    checkOutput("d0_len", 32'(ln), 32'd60);
    checkOutput("d0_seg", 32'(sg), 32'h5B);
    checkOutput("d0_an", 32'(an), 32'hE);
    measureSlot(1, st, ln, sg, an);
    checkOutput("d1_start", 32'(st - rel0), 32'd65);
    checkOutput("d1_len", 32'(ln), 32'd60);
    checkOutput("d1_seg", 32'(sg), 32'h06);
    checkOutput("d1_an", 32'(an), 32'hD);

    // Mid-slot write to digit 2 leaves the current slot untouched
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (!an_out[2]) found = 1;
      else @(negedge clk);
    end
    ln = 0;
    while (!an_out[2] && ln < 1000) begin
      cfg_we    = (ln == 10);
      cfg_addr  = 3'd2;
      cfg_level = 4'd3;
      @(negedge clk);
      ln++;
    end
    cfg_we = 1'b0;
    checkOutput("d2_cur_len", 32'(ln), 32'd60);
    measureSlot(2, st2, ln2, sg, an);
    checkOutput("d2_next_start", 32'(st2 - rel0), 32'd375);
    checkOutput("d2_next_len", 32'(ln2), 32'd12);
    checkOutput("d2_seg", 32'(sg), 32'h3F);
    measureSlot(3, st3, ln3, sg, an);
    checkOutput("d2_dark_gap", 32'(st3 - (st2 + ln2)), 32'd50);
    checkOutput("d3_len", 32'(ln3), 32'd60);

    // Level 0 on digit 1 keeps it dark for a whole frame
    applyStimulus(3'd1, 4'd0);
    waitTick(at);
    frameScan();
    checkFrame("lvl0", 60, 0, 12, 60);

    // Write to digit 0 in the same cycle as its level latch
    cfg_we    = 1'b1;
    cfg_addr  = 3'd0;
    cfg_level = 4'd5;
    frameScan();
    checkFrame("latch_old", 60, 0, 12, 60);
    frameScan();
    checkFrame("latch_new", 20, 0, 12, 60);

    // Restore full brightness, then breathe
    applyStimulus(3'd1, 4'd15);
    applyStimulus(3'd2, 4'd15);
    applyStimulus(3'd0, 4'd15);
    waitTick(at);
    fade_en = 1'b1;
    frameScan();
    checkFrame("fade_f0", 60, 60, 60, 60);
    for (int f = 1; f <= 34; f++) begin
      k   = (f - 1) / 2;
      lvl = (k <= 15) ? (15 - k) : (k - 15);
      frameScan();
      checkFrame($sformatf("fade_f%0d", f), 4*lvl, 4*lvl, 4*lvl, 4*lvl);
    end
    fade_en = 1'b0;
    frameScan();
    checkFrame("fade_drop", 8, 60, 60, 60);
    frameScan();
    checkFrame("fade_off", 60, 60, 60, 60);

    // Asynchronous reset in the middle of an on-window
    applyStimulus(3'd1, 4'd7);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (!an_out[0]) found = 1;
    end
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_an", 32'(an_out), 32'hE);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_an", 32'(an_out), 32'hF);
    checkOutput("async_rst_seg", 32'(seg_out), 32'hFF);
    seg_in = 32'hA1B2C3D4;
    repeat (2) @(negedge clk);
    checkOutput("rst_hold_an", 32'(an_out), 32'hF);
    rst_n = 1'b1;
    rel0  = cyc;
    measureSlot(0, st, ln, sg, an);
    checkOutput("rst_d0_start", 32'(st - rel0), 32'd3);
    checkOutput("rst_d0_len", 32'(ln), 32'd60);
    checkOutput("rst_d0_seg", 32'(sg), 32'hD4);
    measureSlot(1, st, ln, sg, an);
    checkOutput("rst_d1_start", 32'(st - rel0), 32'd65);
    checkOutput("rst_d1_len", 32'(ln), 32'd60);
    checkOutput("rst_d1_seg", 32'(sg), 32'hC3);
    waitTick(at);
    checkOutput("rst_first_tick", 32'(at - rel0), 32'd248);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
